// File: rtl/musa_prog_loader_if.sv
// ---------------------------------------------------------------------------
// musa_prog_loader_if
//   Bundles the byte-stream handshake and the memory write port of the MUSA
//   program loader.
//
//   Stream side : in_data, in_valid (from the byte source), in_ready (back).
//   Memory side : mem_we, mem_sel, mem_addr, mem_wdata (towards dataPath).
//
//   Modports
//     slave  - the loader: consumes the byte stream, drives the write port.
//     master - the byte source / observer: drives the stream, watches writes.
// ---------------------------------------------------------------------------
interface musa_prog_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic                  mem_sel;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_sel,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_sel,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/musa_prog_loader.sv
// ---------------------------------------------------------------------------
// musa_prog_loader
//   Receives a framed byte stream and writes 32-bit words into the MUSA
//   instruction or data memory, holding the core in reset until a frame with
//   a good checksum has been loaded.
//
//   Frame: 0xA5, target (0x00 imem / 0x01 dmem), count_lo, count_hi,
//          count*4 payload bytes (little-endian per word), XOR checksum.
//
//   Ports
//     clk            system clock
//     rst            synchronous active-high reset
//     bus            stream + memory write port (slave modport)
//     core_rst_hold  high while the core must stay in reset
//     done           last frame loaded with a good checksum
//     error          last frame rejected
// ---------------------------------------------------------------------------
module musa_prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  musa_prog_loader_if.slave bus,
  output logic              core_rst_hold,
  output logic              done,
  output logic              error
);

  localparam logic [7:0]  HDR_BYTE  = 8'hA5;
  localparam logic [7:0]  TGT_IMEM  = 8'h00;
  localparam logic [7:0]  TGT_DMEM  = 8'h01;
  // Largest legal word count; compared one bit wider so 2^ADDR_WIDTH fits.
  localparam logic [16:0] MAX_COUNT = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TARGET = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_CNT_HI = 3'd3,
    ST_DATA   = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  // Running payload checksum step.
  function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                             input logic [7:0] data);
    return acc ^ data;
  endfunction

  state_t                state_r,     state_s;
  logic                  in_ready_r,  in_ready_s;
  logic                  mem_we_r,    mem_we_s;
  logic                  mem_sel_r,   mem_sel_s;
  logic [ADDR_WIDTH-1:0] mem_addr_r,  mem_addr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_r, mem_wdata_s;
  logic                  hold_r,      hold_s;
  logic                  done_r,      done_s;
  logic                  error_r,     error_s;
  logic [7:0]            cnt_lo_r,    cnt_lo_s;
  logic [ADDR_WIDTH-1:0] last_idx_r,  last_idx_s;
  logic [ADDR_WIDTH-1:0] word_idx_r,  word_idx_s;
  logic [1:0]            byte_idx_r,  byte_idx_s;
  logic [23:0]           word_buf_r,  word_buf_s;
  logic [7:0]            csum_r,      csum_s;

  logic                  accept_s;
  logic [15:0]           count_s;

  // A byte is consumed whenever the source offers one and we advertise ready.
  assign accept_s = bus.in_valid & in_ready_r;
  // Full word count as seen while the high count byte is on the bus.
  assign count_s  = {bus.in_data, cnt_lo_r};

  // Next-state and next-output logic for the frame parser.
  always_comb begin
    state_s     = state_r;
    in_ready_s  = 1'b1;
    mem_we_s    = 1'b0;
    mem_sel_s   = mem_sel_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    hold_s      = hold_r;
    done_s      = done_r;
    error_s     = error_r;
    cnt_lo_s    = cnt_lo_r;
    last_idx_s  = last_idx_r;
    word_idx_s  = word_idx_r;
    byte_idx_s  = byte_idx_r;
    word_buf_s  = word_buf_r;
    csum_s      = csum_r;

    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_data == HDR_BYTE) begin
            state_s = ST_TARGET;
            csum_s  = 8'h00;
          end else begin
            state_s = ST_IDLE;
          end
        end

        ST_TARGET: begin
          if ((bus.in_data == TGT_IMEM) || (bus.in_data == TGT_DMEM)) begin
            mem_sel_s = bus.in_data[0];
            state_s   = ST_CNT_LO;
          end else begin
            state_s = ST_ERROR;
            error_s = 1'b1;
            hold_s  = 1'b1;
          end
        end

        ST_CNT_LO: begin
          cnt_lo_s = bus.in_data;
          state_s  = ST_CNT_HI;
        end

        ST_CNT_HI: begin
          // Oversized frames are rejected here, before any write can wrap.
          if ({1'b0, count_s} > MAX_COUNT) begin
            state_s = ST_ERROR;
            error_s = 1'b1;
            hold_s  = 1'b1;
          end else if (count_s == 16'd0) begin
            state_s = ST_CHECK;
            csum_s  = 8'h00;
          end else begin
            state_s    = ST_DATA;
            last_idx_s = ADDR_WIDTH'(count_s - 16'd1);
            word_idx_s = '0;
            byte_idx_s = 2'd0;
            word_buf_s = 24'h000000;
            csum_s     = 8'h00;
          end
        end

        ST_DATA: begin
          // Every payload byte (0xA5 included) is data here, never a resync.
          csum_s     = csum_update(csum_r, bus.in_data);
          byte_idx_s = byte_idx_r + 2'd1;
          case (byte_idx_r)
            2'd0: word_buf_s[7:0]   = bus.in_data;
            2'd1: word_buf_s[15:8]  = bus.in_data;
            2'd2: word_buf_s[23:16] = bus.in_data;
            2'd3: begin
              // Fourth lane completes the word; the strobe is registered so
              // it appears in the cycle right after this accepting edge.
              mem_we_s    = 1'b1;
              mem_addr_s  = word_idx_r;
              mem_wdata_s = DATA_WIDTH'({bus.in_data, word_buf_r});
              if (word_idx_r == last_idx_r) begin
                state_s = ST_CHECK;
              end else begin
                word_idx_s = word_idx_r + ADDR_WIDTH'(1'b1);
              end
            end
            default: byte_idx_s = 2'd0;
          endcase
        end

        ST_CHECK: begin
          if (bus.in_data == csum_r) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
            hold_s  = 1'b0;
          end else begin
            state_s = ST_ERROR;
            error_s = 1'b1;
            hold_s  = 1'b1;
          end
        end

        ST_DONE: begin
          // A new header re-arms the core reset before any new write lands.
          if (bus.in_data == HDR_BYTE) begin
            state_s = ST_TARGET;
            done_s  = 1'b0;
            hold_s  = 1'b1;
            csum_s  = 8'h00;
          end else begin
            state_s = ST_DONE;
          end
        end

        ST_ERROR: begin
          if (bus.in_data == HDR_BYTE) begin
            state_s = ST_TARGET;
            error_s = 1'b0;
            csum_s  = 8'h00;
          end else begin
            state_s = ST_ERROR;
          end
        end

        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      // No byte this cycle: everything holds, only the strobe drops.
      state_s = state_r;
    end
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_sel_r   <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      hold_r      <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      cnt_lo_r    <= 8'h00;
      last_idx_r  <= '0;
      word_idx_r  <= '0;
      byte_idx_r  <= 2'd0;
      word_buf_r  <= 24'h000000;
      csum_r      <= 8'h00;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= in_ready_s;
      mem_we_r    <= mem_we_s;
      mem_sel_r   <= mem_sel_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      hold_r      <= hold_s;
      done_r      <= done_s;
      error_r     <= error_s;
      cnt_lo_r    <= cnt_lo_s;
      last_idx_r  <= last_idx_s;
      word_idx_r  <= word_idx_s;
      byte_idx_r  <= byte_idx_s;
      word_buf_r  <= word_buf_s;
      csum_r      <= csum_s;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_sel    = mem_sel_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign core_rst_hold  = hold_r;
  assign done           = done_r;
  assign error          = error_r;

endmodule

// File: tb/tb_musa_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_musa_prog_loader
//   Drives framed byte streams into musa_prog_loader and checks every cycle's
//   outputs against a frame-level model: the model knows which stream byte
//   completes each word and which byte ends the frame, and derives expected
//   writes and status from the payload with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_musa_prog_loader;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst_hold, done, error;

  musa_prog_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  musa_prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .core_rst_hold (core_rst_hold),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit tog = 1'b1;

  // Model view of the outputs for the current cycle.
  logic          exp_ready, exp_we, exp_sel, exp_done, exp_error, exp_hold;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;

  logic [7:0]       pay_q[$];
  logic [DW+AW:0]   wlog[$];   // observed writes {sel, addr, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",      32'(bus.in_ready),  32'(exp_ready));
      check("mem_we",        32'(bus.mem_we),    32'(exp_we));
      check("mem_sel",       32'(bus.mem_sel),   32'(exp_sel));
      check("mem_addr",      32'(bus.mem_addr),  32'(exp_addr));
      check("mem_wdata",     bus.mem_wdata,      exp_wdata);
      check("done",          32'(done),          32'(exp_done));
      check("error",         32'(error),         32'(exp_error));
      check("core_rst_hold", 32'(core_rst_hold), 32'(exp_hold));
      if (bus.mem_we === 1'b1) wlog.push_back({bus.mem_sel, bus.mem_addr, bus.mem_wdata});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    exp_we = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  // mode 0: valid every cycle, 1: valid toggles 1/0, 2: random valid.
  task automatic send_byte(input logic [7:0] d, input int mode);
    bit   acc = 1'b0;
    int   tries = 0;
    logic v;
    while (!acc) begin
      case (mode)
        1:       begin v = tog; tog = ~tog; end
        2:       v = 1'($urandom_range(0, 1));
        default: v = 1'b1;
      endcase
      bus.in_data  = d;
      bus.in_valid = v;
      acc = v && exp_ready;
      tick();
      tries++;
      if (!acc && tries > 64) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_byte: byte 0x%02h not accepted in 64 cycles", d);
        acc = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_ready = 1'b0; exp_we = 1'b0; exp_sel = 1'b0; exp_addr = '0;
    exp_wdata = '0;   exp_done = 1'b0; exp_error = 1'b0; exp_hold = 1'b1;
    chk_en = 1'b1;
    rst = 1'b0;
    tick();
    exp_ready = 1'b1;
  endtask

  function automatic logic [7:0] xor_q();
    logic [7:0] x = 8'h00;
    foreach (pay_q[i]) x ^= pay_q[i];
    return x;
  endfunction

  task automatic fill_random(input int words);
    pay_q.delete();
    for (int i = 0; i < words * 4; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Sends one frame from pay_q. csum_ovr < 0 sends the true checksum,
  // otherwise that byte is sent. abort_at >= 0 pulses reset before that
  // payload byte.
  task automatic run_frame(input logic [7:0] tgt, input int cnt, input int csum_ovr,
                           input int mode, input int abort_at);
    logic [7:0] good = xor_q();
    logic [7:0] sent = (csum_ovr < 0) ? good : 8'(csum_ovr);
    send_byte(8'hA5, mode);
    exp_done = 1'b0; exp_error = 1'b0; exp_hold = 1'b1;
    send_byte(tgt, mode);
    if (tgt > 8'h01) begin
      exp_error = 1'b1;
      return;
    end
    exp_sel = tgt[0];
    send_byte(cnt[7:0], mode);
    send_byte(cnt[15:8], mode);
    if (cnt > (1 << AW)) begin
      exp_error = 1'b1;
      return;
    end
    for (int k = 0; k < cnt * 4; k++) begin
      if (k == abort_at) begin
        do_reset();
        return;
      end
      send_byte(pay_q[k], mode);
      if (k % 4 == 3) begin
        exp_we    = 1'b1;
        exp_addr  = AW'(k / 4);
        exp_wdata = {pay_q[k], pay_q[k-1], pay_q[k-2], pay_q[k-3]};
      end
    end
    send_byte(sent, mode);
    if (sent == good) begin
      exp_done = 1'b1;
      exp_hold = 1'b0;
    end else begin
      exp_error = 1'b1;
    end
  endtask

  task automatic check_directed_writes(input string tag);
    check({tag, "_nwr"}, wlog.size(), 32'd2);
    if (wlog.size() == 2) begin
      check({tag, "_w0"}, wlog[0][31:0], 32'h12345678);
      check({tag, "_a0"}, 32'(wlog[0][41:32]), 32'd0);
      check({tag, "_w1"}, wlog[1][31:0], 32'hDEADBEEF);
      check({tag, "_a1"}, 32'(wlog[1][41:32]), 32'd1);
    end
  endtask

  task automatic load_directed();
    pay_q = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    exp_ready = 1'b0; exp_we = 1'b0; exp_sel = 1'b0; exp_addr = '0;
    exp_wdata = '0;   exp_done = 1'b0; exp_error = 1'b0; exp_hold = 1'b1;

    do_reset();
    check("reset_hold", 32'(core_rst_hold), 32'd1);
    check("reset_done", 32'(done), 32'd0);

    // Good directed frame: XOR of the eight payload bytes is 0x2A.
    load_directed();
    check("csum_model", 32'(xor_q()), 32'h2A);
    wlog.delete();
    run_frame(8'h00, 2, -1, 0, -1);
    idle(2);
    check_directed_writes("good");
    check("good_done", 32'(done), 32'd1);
    check("good_hold", 32'(core_rst_hold), 32'd0);

    // Ignored byte while done.
    send_byte(8'h3C, 0);
    idle(1);

    // Same payload with checksum 0x09, then with 0x08: both rejected.
    wlog.delete();
    run_frame(8'h00, 2, 8'h09, 0, -1);
    idle(2);
    check_directed_writes("bad09");
    check("bad09_error", 32'(error), 32'd1);
    check("bad09_done", 32'(done), 32'd0);
    check("bad09_hold", 32'(core_rst_hold), 32'd1);
    run_frame(8'h00, 2, 8'h08, 0, -1);
    idle(1);
    check("bad08_error", 32'(error), 32'd1);

    // Empty frame to data memory.
    pay_q.delete();
    wlog.delete();
    run_frame(8'h01, 0, 8'h00, 0, -1);
    idle(2);
    check("empty_nwr", wlog.size(), 32'd0);
    check("empty_sel", 32'(bus.mem_sel), 32'd1);
    check("empty_done", 32'(done), 32'd1);

    // Bad target, then recovery.
    run_frame(8'h02, 0, -1, 0, -1);
    idle(1);
    check("badtgt_error", 32'(error), 32'd1);
    fill_random(3);
    run_frame(8'h00, 3, -1, 0, -1);
    idle(1);
    check("recover_done", 32'(done), 32'd1);
    check("recover_error", 32'(error), 32'd0);

    // Valid toggling every cycle.
    load_directed();
    wlog.delete();
    run_frame(8'h00, 2, -1, 1, -1);
    idle(2);
    check_directed_writes("toggle");

    // 1025 words: rejected before any write.
    pay_q.delete();
    wlog.delete();
    run_frame(8'h00, 1025, -1, 0, -1);
    idle(2);
    check("over_nwr", wlog.size(), 32'd0);
    check("over_error", 32'(error), 32'd1);

    // Reset after two payload bytes, then a clean frame.
    fill_random(2);
    run_frame(8'h01, 2, -1, 0, 2);
    idle(1);
    check("rst_sel", 32'(bus.mem_sel), 32'd0);
    check("rst_hold", 32'(core_rst_hold), 32'd1);
    load_directed();
    wlog.delete();
    run_frame(8'h00, 2, -1, 0, -1);
    idle(2);
    check_directed_writes("postrst");

    // 0xA5 inside the payload is plain data.
    fill_random(2);
    pay_q[0] = 8'hA5;
    pay_q[5] = 8'hA5;
    run_frame(8'h01, 2, -1, 2, -1);
    idle(1);
    check("a5pay_done", 32'(done), 32'd1);

    // Randomized frames with junk, gaps and occasional corruption.
    for (int f = 0; f < 16; f++) begin
      int         n_junk = $urandom_range(0, 2);
      int         cnt    = $urandom_range(0, 6);
      int         mode   = $urandom_range(0, 2);
      int         ovr    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : -1;
      logic [7:0] tgt    = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
      for (int j = 0; j < n_junk; j++) begin
        logic [7:0] jb = 8'($urandom_range(0, 255));
        if (jb == 8'hA5) jb = 8'h00;
        send_byte(jb, mode);
      end
      fill_random(cnt);
      run_frame(tgt, cnt, ovr, mode, -1);
      idle($urandom_range(0, 3));
    end

    // Largest legal frame: last address is all ones.
    fill_random(1 << AW);
    wlog.delete();
    run_frame(8'h01, 1 << AW, -1, 0, -1);
    idle(2);
    check("max_nwr", wlog.size(), 32'd1024);
    if (wlog.size() > 0) check("max_last_addr", 32'(wlog[wlog.size()-1][41:32]), 32'h3FF);
    check("max_done", 32'(done), 32'd1);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: run did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
